// File: rtl/corexy_move_sequencer.sv
// ---------------------------------------------------------------------------
// corexy_move_sequencer
//
// Purpose:
//   Turns a Cartesian move (dx, dy, half-period) into CoreXY motor commands
//   for the two-motor stepper driver. Motor 1 runs a = dx+dy steps and
//   motor 2 runs b = dx-dy steps. The longer motor runs at the commanded
//   half-period. The shorter motor's half-period is stretched to
//   floor(period*L/S) so that both motors finish together. The block then
//   runs the start_driving / steppers_driving handshake with the driver and
//   reports completion, endstop aborts and the steps left on each motor.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (ready only while idle)
//   cmd_dx, cmd_dy           signed X / Y step counts
//   cmd_period               half-period (clocks) for the longer motor
//   abort                    cancel the running move (START / RUN only)
//   steppers_driving         driver is moving the motors
//   stepper_step_out_1/2     driver's remaining step counts
//   stepper_step_in_1/2      signed step counts handed to the driver
//   stepper_speed_1/2        half-periods handed to the driver
//   start_driving            start request to the driver
//   busy                     a move is being processed
//   done                     one-cycle pulse when a move (or a null move) ends
//   cmd_err                  one-cycle pulse when a command is rejected
//   endstop_abort            sticky: last move stopped with steps left
//   rem_1, rem_2             remaining steps captured at the end of a move
// ---------------------------------------------------------------------------
module corexy_move_sequencer #(
    parameter int MIN_PERIOD    = 2,
    parameter int START_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_dx,
    input  logic [31:0] cmd_dy,
    input  logic [31:0] cmd_period,
    input  logic        abort,
    input  logic        steppers_driving,
    input  logic [31:0] stepper_step_out_1,
    input  logic [31:0] stepper_step_out_2,
    output logic [31:0] stepper_step_in_1,
    output logic [31:0] stepper_speed_1,
    output logic [31:0] stepper_step_in_2,
    output logic [31:0] stepper_speed_2,
    output logic        start_driving,
    output logic        busy,
    output logic        done,
    output logic        cmd_err,
    output logic        endstop_abort,
    output logic [31:0] rem_1,
    output logic [31:0] rem_2
);

    // Magnitudes at or above 2^30 are rejected.
    localparam logic [32:0] MAG_LIMIT    = 33'h0_4000_0000;
    localparam logic [31:0] MIN_PERIOD_W = 32'(MIN_PERIOD);
    localparam logic [6:0]  DIV_LAST     = 7'd63;
    localparam logic [6:0]  START_LAST   = 7'(START_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CALC,
        S_MUL,
        S_DIV,
        S_LOAD,
        S_START,
        S_RUN,
        S_FINISH,
        S_GAP
    } state_t;

    state_t      state_reg, state_next;

    logic [31:0] dx_reg, dy_reg, period_reg;
    logic [31:0] long_reg, short_reg;
    logic        a_longer_reg, b_longer_reg;
    logic [63:0] prod_reg;
    logic [63:0] quot_reg;
    logic [31:0] div_rem_reg;
    logic [6:0]  cnt_reg;
    logic        abort_seen_reg;

    logic [31:0] step_in_1_reg, step_in_2_reg;
    logic [31:0] speed_1_reg, speed_2_reg;
    logic        start_driving_reg, done_reg, cmd_err_reg, endstop_reg;
    logic [31:0] rem_1_reg, rem_2_reg;

    // ---------------------------------------------------------------
    // CALC datapath: 33-bit CoreXY transform and magnitudes
    // ---------------------------------------------------------------
    logic [32:0] sum_ab, diff_ab, mag_a, mag_b;
    logic        calc_reject, calc_zero, a_ge_b;

    always_comb begin
        sum_ab      = {dx_reg[31], dx_reg} + {dy_reg[31], dy_reg};
        diff_ab     = {dx_reg[31], dx_reg} - {dy_reg[31], dy_reg};
        mag_a       = sum_ab[32]  ? (33'd0 - sum_ab)  : sum_ab;
        mag_b       = diff_ab[32] ? (33'd0 - diff_ab) : diff_ab;
        calc_reject = (mag_a >= MAG_LIMIT) || (mag_b >= MAG_LIMIT) ||
                      (period_reg < MIN_PERIOD_W);
        calc_zero   = (sum_ab == 33'd0) && (diff_ab == 33'd0);
        a_ge_b      = (mag_a >= mag_b);
    end

    // ---------------------------------------------------------------
    // Restoring divider step: one quotient bit per clock. The remainder
    // always stays below the divisor, so 32 bits hold it.
    // ---------------------------------------------------------------
    logic [32:0] div_trial;
    logic        div_fits;
    logic [31:0] div_rem_next;
    logic [31:0] quot_sat;

    always_comb begin
        div_trial    = {div_rem_reg, prod_reg[63]};
        div_fits     = (div_trial >= {1'b0, short_reg});
        div_rem_next = div_fits ? 32'(div_trial - {1'b0, short_reg})
                                : div_trial[31:0];
        // No divide when one motor is idle: its speed is irrelevant, so it
        // simply reuses the commanded period.
        if (short_reg == 32'd0) begin
            quot_sat = period_reg;
        end else if (quot_reg[63:32] != 32'd0) begin
            quot_sat = 32'hFFFF_FFFF;
        end else begin
            quot_sat = quot_reg[31:0];
        end
    end

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (cmd_valid) state_next = S_CALC;
            end
            S_CALC: begin
                if (calc_reject || calc_zero) state_next = S_IDLE;
                else                          state_next = S_MUL;
            end
            S_MUL: begin
                if (short_reg == 32'd0) state_next = S_LOAD;
                else                    state_next = S_DIV;
            end
            S_DIV: begin
                if (cnt_reg == DIV_LAST) state_next = S_LOAD;
            end
            S_LOAD: begin
                state_next = S_START;
            end
            S_START: begin
                if (abort)                      state_next = S_FINISH;
                else if (steppers_driving)      state_next = S_RUN;
                else if (cnt_reg == START_LAST) state_next = S_FINISH;
            end
            S_RUN: begin
                if (abort || !steppers_driving) state_next = S_FINISH;
            end
            S_FINISH: begin
                state_next = S_GAP;
            end
            S_GAP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath and registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx_reg            <= '0;
            dy_reg            <= '0;
            period_reg        <= '0;
            long_reg          <= '0;
            short_reg         <= '0;
            a_longer_reg      <= 1'b0;
            b_longer_reg      <= 1'b0;
            prod_reg          <= '0;
            quot_reg          <= '0;
            div_rem_reg       <= '0;
            cnt_reg           <= '0;
            abort_seen_reg    <= 1'b0;
            step_in_1_reg     <= '0;
            step_in_2_reg     <= '0;
            speed_1_reg       <= '0;
            speed_2_reg       <= '0;
            start_driving_reg <= 1'b0;
            done_reg          <= 1'b0;
            cmd_err_reg       <= 1'b0;
            endstop_reg       <= 1'b0;
            rem_1_reg         <= '0;
            rem_2_reg         <= '0;
        end else begin
            done_reg    <= 1'b0;
            cmd_err_reg <= 1'b0;
            // start_driving follows the state being entered, so it rises on
            // LOAD exit and falls on the same edge that leaves START/RUN.
            start_driving_reg <= (state_next == S_START) || (state_next == S_RUN);

            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid) begin
                        dx_reg         <= cmd_dx;
                        dy_reg         <= cmd_dy;
                        period_reg     <= cmd_period;
                        endstop_reg    <= 1'b0;
                        abort_seen_reg <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (calc_reject) begin
                        cmd_err_reg <= 1'b1;
                    end else if (calc_zero) begin
                        done_reg <= 1'b1;
                    end else begin
                        step_in_1_reg <= sum_ab[31:0];
                        step_in_2_reg <= diff_ab[31:0];
                        long_reg      <= a_ge_b ? mag_a[31:0] : mag_b[31:0];
                        short_reg     <= a_ge_b ? mag_b[31:0] : mag_a[31:0];
                        a_longer_reg  <= (mag_a > mag_b);
                        b_longer_reg  <= (mag_b > mag_a);
                    end
                end
                S_MUL: begin
                    prod_reg    <= 64'(period_reg) * 64'(long_reg);
                    quot_reg    <= '0;
                    div_rem_reg <= '0;
                    cnt_reg     <= '0;
                end
                S_DIV: begin
                    div_rem_reg <= div_rem_next;
                    quot_reg    <= {quot_reg[62:0], div_fits};
                    prod_reg    <= {prod_reg[62:0], 1'b0};
                    cnt_reg     <= cnt_reg + 7'd1;
                end
                S_LOAD: begin
                    cnt_reg <= '0;
                    if (a_longer_reg) begin
                        speed_1_reg <= period_reg;
                        speed_2_reg <= quot_sat;
                    end else if (b_longer_reg) begin
                        speed_1_reg <= quot_sat;
                        speed_2_reg <= period_reg;
                    end else begin
                        speed_1_reg <= period_reg;
                        speed_2_reg <= period_reg;
                    end
                end
                S_START: begin
                    cnt_reg <= cnt_reg + 7'd1;
                    if (abort) abort_seen_reg <= 1'b1;
                end
                S_RUN: begin
                    if (abort) abort_seen_reg <= 1'b1;
                end
                S_FINISH: begin
                    rem_1_reg   <= stepper_step_out_1;
                    rem_2_reg   <= stepper_step_out_2;
                    // A deliberate abort is not an endstop event even if
                    // steps remain.
                    endstop_reg <= ((stepper_step_out_1 != 32'd0) ||
                                    (stepper_step_out_2 != 32'd0)) && !abort_seen_reg;
                    done_reg    <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign cmd_ready         = (state_reg == S_IDLE);
    assign busy              = (state_reg != S_IDLE);
    assign stepper_step_in_1 = step_in_1_reg;
    assign stepper_step_in_2 = step_in_2_reg;
    assign stepper_speed_1   = speed_1_reg;
    assign stepper_speed_2   = speed_2_reg;
    assign start_driving     = start_driving_reg;
    assign done              = done_reg;
    assign cmd_err           = cmd_err_reg;
    assign endstop_abort     = endstop_reg;
    assign rem_1             = rem_1_reg;
    assign rem_2             = rem_2_reg;

endmodule

// File: tb/tb_corexy_move_sequencer.sv
// ---------------------------------------------------------------------------
// tb_corexy_move_sequencer
//
// Scoreboard bench for corexy_move_sequencer. Each command pushes its
// expected CoreXY results (from an independent arithmetic model) onto a
// queue. A monitor compares the outputs when start_driving rises and pops
// the entry when done or cmd_err pulses. A behavioural driver model answers
// the start_driving handshake.
// ---------------------------------------------------------------------------
module tb_corexy_move_sequencer;

    localparam int MIN_P   = 2;
    localparam int START_TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_dx, cmd_dy, cmd_period;
    logic        abort;
    logic        steppers_driving;
    logic [31:0] stepper_step_out_1, stepper_step_out_2;
    logic [31:0] stepper_step_in_1, stepper_speed_1;
    logic [31:0] stepper_step_in_2, stepper_speed_2;
    logic        start_driving, busy, done, cmd_err, endstop_abort;
    logic [31:0] rem_1, rem_2;

    corexy_move_sequencer #(
        .MIN_PERIOD    (MIN_P),
        .START_TIMEOUT (START_TO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_dx             (cmd_dx),
        .cmd_dy             (cmd_dy),
        .cmd_period         (cmd_period),
        .abort              (abort),
        .steppers_driving   (steppers_driving),
        .stepper_step_out_1 (stepper_step_out_1),
        .stepper_step_out_2 (stepper_step_out_2),
        .stepper_step_in_1  (stepper_step_in_1),
        .stepper_speed_1    (stepper_speed_1),
        .stepper_step_in_2  (stepper_step_in_2),
        .stepper_speed_2    (stepper_speed_2),
        .start_driving      (start_driving),
        .busy               (busy),
        .done               (done),
        .cmd_err            (cmd_err),
        .endstop_abort      (endstop_abort),
        .rem_1              (rem_1),
        .rem_2              (rem_2)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = real move, 1 = null move, 2 = rejected
    typedef struct {
        int          kind;
        logic [31:0] s1, s2, v1, v2, r1, r2;
        logic        es;
        longint      lat;
        longint      acc;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Independent reference model of the CoreXY conversion.
    function automatic exp_t model(input logic signed [31:0] dx, input logic signed [31:0] dy,
                                   input logic [31:0] per);
        exp_t   e;
        longint a, b, aa, bb, l, s, q, p;
        a  = longint'(dx) + longint'(dy);
        b  = longint'(dx) - longint'(dy);
        aa = (a < 0) ? -a : a;
        bb = (b < 0) ? -b : b;
        p  = longint'({32'd0, per});
        e.s1 = a[31:0];
        e.s2 = b[31:0];
        e.v1 = '0; e.v2 = '0; e.r1 = '0; e.r2 = '0; e.es = 1'b0; e.acc = 0;
        if (aa >= 64'h4000_0000 || bb >= 64'h4000_0000 || p < MIN_P) begin
            e.kind = 2;
        end else if (a == 0 && b == 0) begin
            e.kind = 1;
        end else begin
            e.kind = 0;
        end
        l = (aa > bb) ? aa : bb;
        s = (aa > bb) ? bb : aa;
        if (s == 0) q = p;
        else        q = (p * l) / s;
        if (q >= 64'h1_0000_0000) q = 64'hFFFF_FFFF;
        if (aa > bb)      begin e.v1 = per;     e.v2 = q[31:0]; end
        else if (bb > aa) begin e.v1 = q[31:0]; e.v2 = per;     end
        else              begin e.v1 = per;     e.v2 = per;     end
        e.lat = (s == 0) ? 3 : 67;
        return e;
    endfunction

    // ---------------- driver model ----------------
    int          drv_run     = 10;
    logic [31:0] drv_rem1    = '0;
    logic [31:0] drv_rem2    = '0;
    bit          drv_respond = 1'b1;
    int          drv_cnt     = 0;
    bit          drv_running = 1'b0;
    bit          drv_armed   = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            steppers_driving   = 1'b0;
            stepper_step_out_1 = '0;
            stepper_step_out_2 = '0;
            drv_running        = 1'b0;
            drv_armed          = 1'b1;
        end else if (drv_running) begin
            if (!start_driving || drv_cnt == 0) begin
                steppers_driving   = 1'b0;
                drv_running        = 1'b0;
                stepper_step_out_1 = drv_rem1;
                stepper_step_out_2 = drv_rem2;
            end else begin
                drv_cnt--;
            end
        end else if (!start_driving) begin
            drv_armed = 1'b1;
        end else if (drv_armed && drv_respond) begin
            steppers_driving   = 1'b1;
            drv_running        = 1'b1;
            drv_armed          = 1'b0;
            drv_cnt            = drv_run;
            stepper_step_out_1 = 32'd99;
            stepper_step_out_2 = 32'd99;
        end
    end

    // ---------------- monitor ----------------
    bit   sd_prev   = 1'b0;
    bit   saw_start = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            sd_prev   = 1'b0;
            saw_start = 1'b0;
        end else begin
            if (start_driving && !sd_prev) begin
                saw_start = 1'b1;
                if (sb.size() == 0) begin
                    chk("start_without_cmd", 64'd1, 64'd0);
                end else begin
                    mon_e = sb[0];
                    chk("step_in_1", 64'(stepper_step_in_1), 64'(mon_e.s1));
                    chk("step_in_2", 64'(stepper_step_in_2), 64'(mon_e.s2));
                    chk("speed_1",   64'(stepper_speed_1),   64'(mon_e.v1));
                    chk("speed_2",   64'(stepper_speed_2),   64'(mon_e.v2));
                    chk("start_latency", 64'(cyc - mon_e.acc - 1), 64'(mon_e.lat));
                end
            end
            if (done || cmd_err) begin
                if (sb.size() == 0) begin
                    chk("end_without_cmd", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("end_kind", 64'(cmd_err ? 2 : (saw_start ? 0 : 1)), 64'(mon_e.kind));
                    if (mon_e.kind == 0) begin
                        chk("rem_1", 64'(rem_1), 64'(mon_e.r1));
                        chk("rem_2", 64'(rem_2), 64'(mon_e.r2));
                        chk("endstop_abort", 64'(endstop_abort), 64'(mon_e.es));
                    end else begin
                        chk("end_within_2clk", 64'((cyc - mon_e.acc - 1) <= 2), 64'd1);
                        chk("ready_after_end", 64'({busy, cmd_ready}), 64'b01);
                    end
                    $display("txn kind=%0d step=%h/%h speed=%h/%h rem=%h/%h es=%0b",
                             mon_e.kind, mon_e.s1, mon_e.s2, mon_e.v1, mon_e.v2,
                             rem_1, rem_2, endstop_abort);
                end
                saw_start = 1'b0;
            end
            sd_prev = start_driving;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic signed [31:0] dx, input logic signed [31:0] dy,
                        input logic [31:0] per, input logic [31:0] r1,
                        input logic [31:0] r2, input logic es);
        exp_t e;
        int   w;
        w = 0;
        while ((!cmd_ready || sb.size() != 0) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) chk("send_ready_timeout", 64'd1, 64'd0);
        e    = model(dx, dy, per);
        e.r1 = r1;
        e.r2 = r2;
        e.es = es;
        @(negedge clk);
        cmd_dx     = dx;
        cmd_dy     = dy;
        cmd_period = per;
        cmd_valid  = 1'b1;
        e.acc      = cyc;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("accept_busy", 64'(busy), 64'd1);
        chk("accept_clears_endstop", 64'(endstop_abort), 64'd0);
    endtask

    task automatic wait_drained();
        int w;
        w = 0;
        while ((sb.size() != 0 || !cmd_ready) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_driving();
        int w;
        w = 0;
        while (!steppers_driving && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("driving_timeout", 64'd1, 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_dx     = '0;
        cmd_dy     = '0;
        cmd_period = '0;
        abort      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_flags", 64'({start_driving, busy, done, cmd_err, endstop_abort}), 64'd0);
        chk("rst_step_speed", 64'(stepper_step_in_1 | stepper_step_in_2 |
                                  stepper_speed_1 | stepper_speed_2), 64'd0);
        chk("rst_rem", 64'(rem_1 | rem_2), 64'd0);
        rst = 1'b0;

        send(32'sd100, 32'sd0, 32'd50, 32'd0, 32'd0, 1'b0);
        send(32'sd100, 32'sd50, 32'd50, 32'd0, 32'd0, 1'b0);
        send(-32'sd30, 32'sd10, 32'd40, 32'd0, 32'd0, 1'b0);
        send(32'sd0, 32'sd0, 32'd10, 32'd0, 32'd0, 1'b0);
        send(32'sd1073741824, 32'sd1073741824, 32'd50, 32'd0, 32'd0, 1'b0);
        send(32'sd5, 32'sd0, 32'd1, 32'd0, 32'd0, 1'b0);
        send(32'sd5, 32'sd3, 32'd2, 32'd0, 32'd0, 1'b0);
        drv_run = 5;
        send(32'sd500000000, 32'sd499999999, 32'd1000, 32'd0, 32'd0, 1'b0);
        wait_drained();

        // early stop with steps left -> endstop_abort
        drv_rem1 = 32'd7;
        drv_rem2 = 32'hFFFF_FFFD;
        send(32'sd40, 32'sd0, 32'd3, 32'd7, 32'hFFFF_FFFD, 1'b1);
        wait_drained();
        drv_rem1 = '0;
        drv_rem2 = '0;
        send(32'sd10, 32'sd10, 32'd4, 32'd0, 32'd0, 1'b0);
        wait_drained();

        // driver never answers -> start timeout ends the move
        drv_respond = 1'b0;
        send(32'sd10, 32'sd0, 32'd5, 32'd0, 32'd0, 1'b0);
        wait_drained();
        drv_respond = 1'b1;

        // abort during RUN
        drv_run  = 40;
        drv_rem1 = 32'd20;
        drv_rem2 = 32'd20;
        send(32'sd60, 32'sd0, 32'd5, 32'd20, 32'd20, 1'b0);
        wait_driving();
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_drops_start", 64'(start_driving), 64'd0);
        wait_drained();

        // asynchronous reset during RUN
        drv_rem1 = '0;
        drv_rem2 = '0;
        send(32'sd60, 32'sd0, 32'd5, 32'd0, 32'd0, 1'b0);
        wait_driving();
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_run_start_driving", 64'(start_driving), 64'd0);
        chk("rst_run_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_run_flags", 64'({busy, done, cmd_err, endstop_abort}), 64'd0);
        chk("rst_run_step_speed", 64'(stepper_step_in_1 | stepper_step_in_2 |
                                      stepper_speed_1 | stepper_speed_2), 64'd0);
        chk("rst_run_rem", 64'(rem_1 | rem_2), 64'd0);
        if (sb.size() != 0) void'(sb.pop_front());
        $display("txn kind=0 move cancelled by reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        drv_run = 10;
        send(32'sd3, 32'sd4, 32'd6, 32'd0, 32'd0, 1'b0);
        wait_drained();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
